// File: rtl/hsv_pixel_sequencer_pkg.sv
// Shared types and constants for the HSV pixel sequencer: FSM encoding,
// colour field widths and default frame geometry.
package hsv_pixel_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_t;

    localparam int unsigned CH_W       = 5;
    localparam int unsigned HUE_W      = 7;
    localparam int unsigned PIX_W      = 16;
    localparam int unsigned DEF_WIDTH  = 320;
    localparam int unsigned DEF_HEIGHT = 240;

    // Inclusive window test; lo > hi yields no match because there is no wrap.
    function automatic logic in_window(input logic [HUE_W-1:0] v,
                                       input logic [HUE_W-1:0] lo,
                                       input logic [HUE_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/hsv_pixel_sequencer_pix_coord_counter.sv
// Pixel x/y coordinate counters with start-of-frame load, raster advance,
// line/frame wrap and a one-cycle frame_done pulse.
module pix_coord_counter #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned XW     = 9,
    parameter int unsigned YW     = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          sof_load,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_done
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (sof_load) begin
                x <= '0;
                y <= '0;
            end else if (advance) begin
                if (x == X_LAST) begin
                    x <= '0;
                    if (y == Y_LAST) begin
                        y          <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        y <= y + YW'(1);
                    end
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/hsv_pixel_sequencer.sv
// Feeds one RGB555 pixel at a time to the rgb2hsv converter and hands the
// HSV result downstream with x/y coordinates. Option macro: HSV_SEQ_MATCH_EN.
module hsv_pixel_sequencer
    import hsv_pixel_sequencer_pkg::*;
#(
    parameter int unsigned CONV_LAT = 3,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned HEIGHT   = DEF_HEIGHT,
    parameter int unsigned XW       = 9,
    parameter int unsigned YW       = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_sof,
    output logic             pix_ready,
    output logic             cv_read,
    output logic [PIX_W-1:0] cv_data,
    input  logic [HUE_W-1:0] cv_hue,
    input  logic [CH_W-1:0]  cv_sat,
    input  logic [CH_W-1:0]  cv_val,
    input  logic             cv_hue_invalid,
    input  logic             cv_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [HUE_W-1:0] out_hue,
    output logic [CH_W-1:0]  out_sat,
    output logic [CH_W-1:0]  out_val,
    output logic             out_invalid,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
`ifdef HSV_SEQ_MATCH_EN
    input  logic [HUE_W-1:0] hue_lo,
    input  logic [HUE_W-1:0] hue_hi,
    input  logic [CH_W-1:0]  sat_min,
    input  logic [CH_W-1:0]  val_min,
    output logic             out_match,
`endif
    output logic             frame_done
);

    localparam int unsigned    LW       = (CONV_LAT < 2) ? 1 : $clog2(CONV_LAT);
    localparam logic [LW-1:0]  LAT_LAST = LW'(CONV_LAT - 1);

    seq_state_t    state, next_state;
    logic [LW-1:0] lat_cnt;
    logic          accept, capture, xfer;

    assign accept  = pix_valid && pix_ready;
    assign xfer    = out_valid && out_ready;
    assign capture = (state == ST_WAIT) && (cv_done || (lat_cnt == LAT_LAST));

    always_comb begin
        next_state = state;
        cv_read    = 1'b0;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_ISSUE;
            ST_ISSUE: begin
                cv_read    = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT:  if (capture) next_state = ST_HOLD;
            ST_HOLD:  if (xfer) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // pix_ready/out_valid are registered from next_state so they match the
    // state they describe and read as 0 for the whole of reset.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state       <= ST_IDLE;
            lat_cnt     <= '0;
            pix_ready   <= 1'b0;
            out_valid   <= 1'b0;
            cv_data     <= '0;
            out_hue     <= '0;
            out_sat     <= '0;
            out_val     <= '0;
            out_invalid <= 1'b0;
        end else begin
            state     <= next_state;
            pix_ready <= (next_state == ST_IDLE);
            out_valid <= (next_state == ST_HOLD);
            if (accept) cv_data <= pix_data;
            if (state == ST_ISSUE) begin
                lat_cnt <= '0;
            end else if (state == ST_WAIT) begin
                lat_cnt <= lat_cnt + LW'(1);
            end
            if (capture) begin
                out_hue     <= cv_hue;
                out_sat     <= cv_sat;
                out_val     <= cv_val;
                out_invalid <= cv_hue_invalid;
            end
        end
    end

`ifdef HSV_SEQ_MATCH_EN
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            out_match <= 1'b0;
        end else if (capture) begin
            out_match <= !cv_hue_invalid && in_window(cv_hue, hue_lo, hue_hi)
                         && (cv_sat >= sat_min) && (cv_val >= val_min);
        end
    end
`endif

    pix_coord_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_coord (
        .clk        (clk),
        .res        (res),
        .sof_load   (accept && pix_sof),
        .advance    (xfer),
        .x          (out_x),
        .y          (out_y),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_hsv_pixel_sequencer.sv
// Table-driven bench for hsv_pixel_sequencer with a converter stub and a
// result scoreboard; define HSV_SEQ_MATCH_EN to cover the match output.
module tb_hsv_pixel_sequencer;

    localparam int unsigned CONV_LAT = 3;
    localparam int unsigned WIDTH    = 4;
    localparam int unsigned HEIGHT   = 2;
    localparam int unsigned XW       = 9;
    localparam int unsigned YW       = 8;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          pix_valid = 1'b0;
    logic [15:0]   pix_data = '0;
    logic          pix_sof = 1'b0;
    logic          pix_ready;
    logic          cv_read;
    logic [15:0]   cv_data;
    logic [6:0]    cv_hue;
    logic [4:0]    cv_sat, cv_val;
    logic          cv_hue_invalid, cv_done;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [6:0]    out_hue;
    logic [4:0]    out_sat, out_val;
    logic          out_invalid;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          frame_done;
`ifdef HSV_SEQ_MATCH_EN
    logic [6:0]    hue_lo = 7'd10;
    logic [6:0]    hue_hi = 7'd20;
    logic [4:0]    sat_min = 5'd8;
    logic [4:0]    val_min = 5'd8;
    logic          out_match;
`endif

    always #5 clk = ~clk;

    hsv_pixel_sequencer #(
        .CONV_LAT (CONV_LAT),
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .XW       (XW),
        .YW       (YW)
    ) dut (
        .clk            (clk),
        .res            (res),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_sof        (pix_sof),
        .pix_ready      (pix_ready),
        .cv_read        (cv_read),
        .cv_data        (cv_data),
        .cv_hue         (cv_hue),
        .cv_sat         (cv_sat),
        .cv_val         (cv_val),
        .cv_hue_invalid (cv_hue_invalid),
        .cv_done        (cv_done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_hue        (out_hue),
        .out_sat        (out_sat),
        .out_val        (out_val),
        .out_invalid    (out_invalid),
        .out_x          (out_x),
        .out_y          (out_y),
`ifdef HSV_SEQ_MATCH_EN
        .hue_lo         (hue_lo),
        .hue_hi         (hue_hi),
        .sat_min        (sat_min),
        .val_min        (val_min),
        .out_match      (out_match),
`endif
        .frame_done     (frame_done)
    );

    typedef struct {
        logic [15:0] data;
        logic        sof;
        int unsigned dly;
        int unsigned hold;
        logic        ovr;
        logic [6:0]  o_hue;
        logic [4:0]  o_sat;
        logic [4:0]  o_val;
        logic        o_inv;
        logic [6:0]  e_hue;
        logic [4:0]  e_sat;
        logic [4:0]  e_val;
        logic        e_inv;
        int unsigned e_x;
        int unsigned e_y;
        logic        e_fd;
        logic        e_match;
    } row_t;

    row_t        tbl [0:17];
    row_t        sb_q [$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pushed = 0;
    int unsigned popped = 0;

    // Converter stub: result fields become correct only inside the window
    // that opens at the done cycle (early) or CONV_LAT cycles after the read.
    logic [3:0]  scnt = '0;
    int unsigned done_dly = 0;
    logic        ovr_en = 1'b0;
    logic [6:0]  ovr_hue = '0;
    logic [4:0]  ovr_sat = '0, ovr_val = '0;
    logic        ovr_inv = 1'b0;

    always @(posedge clk) begin
        if (cv_read) scnt <= 4'd1;
        else if (scnt != 4'd0 && scnt != 4'd15) scnt <= scnt + 4'd1;
    end

    always_comb begin
        logic [4:0]  sr, sg, sb, smax, smin;
        logic [6:0]  mh;
        logic [4:0]  ms, mv;
        logic        mi, win;
        int unsigned wstart;
        sr = cv_data[14:10];
        sg = cv_data[9:5];
        sb = cv_data[4:0];
        smax = (sr > sg) ? sr : sg;
        smax = (sb > smax) ? sb : smax;
        smin = (sr < sg) ? sr : sg;
        smin = (sb < smin) ? sb : smin;
        mh = {sg, sb[1:0]};
        ms = smax - smin;
        mv = smax;
        mi = (smax == smin);
        if (ovr_en) begin
            mh = ovr_hue;
            ms = ovr_sat;
            mv = ovr_val;
            mi = ovr_inv;
        end
        wstart = (done_dly != 0 && done_dly < CONV_LAT) ? done_dly : CONV_LAT;
        win = (scnt != 4'd0) && (int'(scnt) >= wstart);
        cv_hue         = win ? mh : ~mh;
        cv_sat         = win ? ms : ~ms;
        cv_val         = win ? mv : ~mv;
        cv_hue_invalid = win ? mi : ~mi;
        cv_done        = (done_dly != 0) && (int'(scnt) == done_dly);
    end

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Output monitor: samples at negedge, so a handshake seen here completes
    // on the following posedge and frame_done is visible one negedge later.
    logic pend_fd = 1'b0;
    always @(negedge clk) begin
        if (!res) begin
            pend_fd = 1'b0;
        end else begin
            chk(frame_done == pend_fd, "frame_done",
                $sformatf("got %0b want %0b", frame_done, pend_fd));
            pend_fd = 1'b0;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk(1'b0, "unexpected_output", "got a transfer want none");
                end else begin
                    row_t e;
                    e = sb_q.pop_front();
                    popped++;
                    chk(out_hue == e.e_hue && out_sat == e.e_sat && out_val == e.e_val &&
                        out_invalid == e.e_inv && int'(out_x) == e.e_x && int'(out_y) == e.e_y,
                        "result",
                        $sformatf("got h%0d s%0d v%0d i%0b (%0d,%0d) want h%0d s%0d v%0d i%0b (%0d,%0d)",
                                  out_hue, out_sat, out_val, out_invalid, out_x, out_y,
                                  e.e_hue, e.e_sat, e.e_val, e.e_inv, e.e_x, e.e_y));
`ifdef HSV_SEQ_MATCH_EN
                    chk(out_match == e.e_match, "out_match",
                        $sformatf("got %0b want %0b", out_match, e.e_match));
`endif
                    pend_fd = e.e_fd;
                end
            end
        end
    end

    function automatic row_t mk(input logic [15:0] data, input logic sof,
                                input int unsigned dly, input int unsigned hold,
                                input logic ovr, input logic [6:0] oh, input logic [4:0] os,
                                input logic [4:0] ov, input logic oi,
                                input logic [6:0] eh, input logic [4:0] es,
                                input logic [4:0] ev, input logic ei,
                                input int unsigned ex, input int unsigned ey,
                                input logic efd, input logic em);
        row_t r;
        r.data = data; r.sof = sof; r.dly = dly; r.hold = hold;
        r.ovr = ovr; r.o_hue = oh; r.o_sat = os; r.o_val = ov; r.o_inv = oi;
        r.e_hue = eh; r.e_sat = es; r.e_val = ev; r.e_inv = ei;
        r.e_x = ex; r.e_y = ey; r.e_fd = efd; r.e_match = em;
        return r;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (pix_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk(1'b0, "pix_ready_timeout", "got 0 for 20 cycles want 1");
    endtask

    task automatic run_row(input int idx);
        row_t        r;
        bit          ok;
        int unsigned rd_cnt;
        int          rd_first, lat, exp_lat;
        logic [6:0]  sh;
        logic [4:0]  ss, sv;
        logic        si;
        r = tbl[idx];
        ovr_en = r.ovr; ovr_hue = r.o_hue; ovr_sat = r.o_sat;
        ovr_val = r.o_val; ovr_inv = r.o_inv;
        done_dly = r.dly;
        out_ready = (r.hold == 0);
        wait_ready(ok);
        if (!ok) return;
        pix_valid = 1'b1;
        pix_data  = r.data;
        pix_sof   = r.sof;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 16'($urandom);
        sb_q.push_back(r);
        pushed++;
        rd_cnt = 0; rd_first = -1; lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (cv_read) begin
                rd_cnt++;
                if (rd_first < 0) rd_first = i;
            end
            if (out_valid) begin
                lat = i + 1;
                break;
            end
            @(posedge clk); #1;
        end
        exp_lat = (r.dly != 0 && r.dly < CONV_LAT) ? int'(r.dly) + 2 : int'(CONV_LAT) + 2;
        chk(lat == exp_lat, "latency", $sformatf("row %0d got %0d want %0d", idx, lat, exp_lat));
        chk(rd_cnt == 1 && rd_first == 0, "cv_read_pulse",
            $sformatf("row %0d got %0d pulses first %0d want 1 at 0", idx, rd_cnt, rd_first));
        if (r.hold != 0) begin
            sh = out_hue; ss = out_sat; sv = out_val; si = out_invalid;
            for (int h = 0; h < int'(r.hold); h++) begin
                @(posedge clk); #1;
                chk(out_valid && !pix_ready && !cv_read && out_hue == sh && out_sat == ss &&
                    out_val == sv && out_invalid == si, "hold_stable",
                    $sformatf("row %0d cyc %0d got v%0b r%0b rd%0b want v1 r0 rd0 stable",
                              idx, h, out_valid, pix_ready, cv_read));
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk(!out_valid, "out_valid_drop", $sformatf("row %0d got %0b want 0", idx, out_valid));
    endtask

    initial begin
        bit ok;
        tbl[0]  = mk(16'h7C00, 1, 0, 0,  0, 0, 0, 0, 0,  7'd0,   5'd31, 5'd31, 0, 0, 0, 0, 0);
        tbl[1]  = mk(16'h4210, 0, 1, 0,  0, 0, 0, 0, 0,  7'd64,  5'd0,  5'd16, 1, 1, 0, 0, 0);
        tbl[2]  = mk(16'h03E0, 0, 2, 10, 0, 0, 0, 0, 0,  7'd124, 5'd31, 5'd31, 0, 2, 0, 0, 0);
        tbl[3]  = mk(16'h001F, 0, 0, 0,  0, 0, 0, 0, 0,  7'd3,   5'd31, 5'd31, 0, 3, 0, 0, 0);
        tbl[4]  = mk(16'h0421, 0, 3, 0,  0, 0, 0, 0, 0,  7'd5,   5'd0,  5'd1,  1, 0, 1, 0, 0);
        tbl[5]  = mk(16'h1CA5, 0, 0, 0,  0, 0, 0, 0, 0,  7'd21,  5'd2,  5'd7,  0, 1, 1, 0, 0);
        tbl[6]  = mk(16'hA108, 0, 1, 0,  0, 0, 0, 0, 0,  7'd32,  5'd0,  5'd8,  1, 2, 1, 0, 0);
        tbl[7]  = mk(16'h7FFF, 0, 0, 0,  0, 0, 0, 0, 0,  7'd127, 5'd0,  5'd31, 1, 3, 1, 1, 0);
        tbl[8]  = mk(16'h0000, 0, 0, 0,  0, 0, 0, 0, 0,  7'd0,   5'd0,  5'd0,  1, 0, 0, 0, 0);
        tbl[9]  = mk(16'h7C00, 0, 5, 4,  0, 0, 0, 0, 0,  7'd0,   5'd31, 5'd31, 0, 1, 0, 0, 0);
        tbl[10] = mk(16'h03E0, 1, 0, 0,  0, 0, 0, 0, 0,  7'd124, 5'd31, 5'd31, 0, 0, 0, 0, 0);
        tbl[11] = mk(16'h001F, 0, 2, 0,  0, 0, 0, 0, 0,  7'd3,   5'd31, 5'd31, 0, 1, 0, 0, 0);
        tbl[12] = mk(16'h7C00, 0, 0, 0,  0, 0, 0, 0, 0,  7'd0,   5'd31, 5'd31, 0, 0, 0, 0, 0);
        tbl[13] = mk(16'h0000, 0, 0, 0,  1, 7'd20, 5'd8, 5'd8, 0,  7'd20, 5'd8, 5'd8, 0, 1, 0, 0, 1);
        tbl[14] = mk(16'h0000, 0, 0, 0,  1, 7'd21, 5'd8, 5'd8, 0,  7'd21, 5'd8, 5'd8, 0, 2, 0, 0, 0);
        tbl[15] = mk(16'h0000, 0, 1, 0,  1, 7'd15, 5'd9, 5'd9, 1,  7'd15, 5'd9, 5'd9, 1, 3, 0, 0, 0);
        tbl[16] = mk(16'h0000, 0, 0, 0,  1, 7'd10, 5'd8, 5'd8, 0,  7'd10, 5'd8, 5'd8, 0, 0, 1, 0, 1);
        tbl[17] = mk(16'h0000, 0, 0, 0,  1, 7'd15, 5'd7, 5'd8, 0,  7'd15, 5'd7, 5'd8, 0, 1, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk(!pix_ready && !out_valid && !cv_read && !frame_done && out_x == '0 &&
            out_y == '0 && cv_data == '0 && out_hue == '0 && !out_invalid, "reset_state",
            $sformatf("got r%0b v%0b rd%0b fd%0b (%0d,%0d) d%h want all 0",
                      pix_ready, out_valid, cv_read, frame_done, out_x, out_y, cv_data));
        res = 1'b1;

        for (int i = 0; i <= 11; i++) run_row(i);

        // Reset while the converter result is pending: the pixel is dropped.
        done_dly = 0; ovr_en = 1'b0; out_ready = 1'b1;
        wait_ready(ok);
        pix_valid = 1'b1; pix_data = 16'h03E0; pix_sof = 1'b0;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        res = 1'b0;
        #1;
        chk(!pix_ready && !out_valid && !cv_read, "reset_in_wait",
            $sformatf("got r%0b v%0b rd%0b want 0 0 0", pix_ready, out_valid, cv_read));
        repeat (2) @(posedge clk);
        #1;
        res = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk(!out_valid && !cv_read, "no_partial",
                $sformatf("cyc %0d got v%0b rd%0b want 0 0", k, out_valid, cv_read));
        end

        for (int i = 12; i <= 17; i++) run_row(i);

        repeat (4) @(posedge clk);
        #1;
        chk(sb_q.size() == 0 && popped == pushed, "scoreboard_drain",
            $sformatf("got %0d left, %0d of %0d out want 0 left", sb_q.size(), popped, pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
